// File: rtl/ex_mem_stage_if.sv
// Handshake bundle between execute, the ex/mem stage, and the memory stage.
// The stage itself takes the slave view; the surrounding pipeline takes master.
interface ex_mem_stage_if #(
  parameter int XLEN = 32,
  parameter int RW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_sum;
  logic            in_cout;
  logic            in_a_msb;
  logic            in_b_msb;
  logic [1:0]      in_op;
  logic [RW-1:0]   in_rd;
  logic            in_wb_en;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [RW-1:0]   out_rd;
  logic            out_wb_en;
  logic            out_z;
  logic            out_n;
  logic            out_c;
  logic            out_v;
  logic            fwd_valid;
  logic [RW-1:0]   fwd_rd;
  logic [XLEN-1:0] fwd_data;

  modport master (
    output in_valid, in_sum, in_cout, in_a_msb, in_b_msb, in_op, in_rd, in_wb_en,
    output flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wb_en,
    input  out_z, out_n, out_c, out_v, fwd_valid, fwd_rd, fwd_data
  );

  modport slave (
    input  in_valid, in_sum, in_cout, in_a_msb, in_b_msb, in_op, in_rd, in_wb_en,
    input  flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wb_en,
    output out_z, out_n, out_c, out_v, fwd_valid, fwd_rd, fwd_data
  );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute-to-memory stage: flag/SLT derivation from the raw adder result,
// registered through a two-entry skid buffer so out_ready never reaches in_ready.
module ex_mem_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input logic           clk,
  input logic           rst,
  ex_mem_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [RW-1:0]   rd;
    logic            wb_en;
    logic            z;
    logic            n;
    logic            c;
    logic            v;
  } entry_t;

  // State encoding is {skid valid, main valid}; 2'b10 cannot occur.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t state;
  entry_t m_q;
  entry_t s_q;
  entry_t nxt;
  logic   m_valid;
  logic   s_valid;
  logic   accept;
  logic   drain;

  assign m_valid = (state != EMPTY);
  assign s_valid = (state == FULL);
  assign accept  = bus.in_valid & ~s_valid;
  assign drain   = m_valid & bus.out_ready;

  // Flags always describe the raw sum; only the result field depends on in_op.
  always_comb begin
    nxt       = '0;
    nxt.z     = (bus.in_sum == '0);
    nxt.n     = bus.in_sum[XLEN-1];
    nxt.c     = bus.in_cout;
    nxt.v     = (bus.in_a_msb == bus.in_b_msb) & (bus.in_sum[XLEN-1] != bus.in_a_msb);
    nxt.rd    = bus.in_rd;
    nxt.wb_en = bus.in_wb_en & (bus.in_rd != '0);
    case (bus.in_op)
      2'b01:   nxt.result = {{(XLEN-1){1'b0}}, nxt.n ^ nxt.v};
      2'b10:   nxt.result = {{(XLEN-1){1'b0}}, ~bus.in_cout};
      default: nxt.result = bus.in_sum;
    endcase
  end

  // Flush only clears valid bits; a drain in the same cycle was already seen downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      m_q   <= '0;
      s_q   <= '0;
    end else if (bus.flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            m_q   <= nxt;
            state <= ONE;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            s_q   <= nxt;
            state <= FULL;
          end else if (accept && drain) begin
            m_q   <= nxt;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            m_q   <= s_q;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.in_ready   = ~s_valid;
  assign bus.out_valid  = m_valid;
  assign bus.out_result = m_q.result;
  assign bus.out_rd     = m_q.rd;
  assign bus.out_wb_en  = m_q.wb_en;
  assign bus.out_z      = m_q.z;
  assign bus.out_n      = m_q.n;
  assign bus.out_c      = m_q.c;
  assign bus.out_v      = m_q.v;
  assign bus.fwd_valid  = m_valid & m_q.wb_en;
  assign bus.fwd_rd     = m_q.rd;
  assign bus.fwd_data   = m_q.result;

endmodule
